// File: rtl/sr_latch_driver_if.sv
// Request/feedback bundle between control logic and sr_latch_driver.
// master: requester + latch side; slave: the driver.
interface sr_latch_driver_if;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic S;
  logic R;
  logic Q_fb;
  logic Qbar_fb;
  logic done;
  logic err;
  logic busy;

  modport master (
    output req_valid,
    output req_level,
    output Q_fb,
    output Qbar_fb,
    input  req_ready,
    input  S,
    input  R,
    input  done,
    input  err,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_level,
    input  Q_fb,
    input  Qbar_fb,
    output req_ready,
    output S,
    output R,
    output done,
    output err,
    output busy
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Turns a level request into one fixed-width S or R pulse, then checks
// Q/Qbar feedback (done/err). Ports: clk, rst (async high), bus (slave).
module sr_latch_driver #(
  parameter int PULSE_W    = 2,
  parameter int SETTLE_MAX = 8,
  parameter int GAP_W      = 1
) (
  input  logic               clk,
  input  logic               rst,
  sr_latch_driver_if.slave   bus
);

  localparam logic [7:0] PW8 = 8'(PULSE_W);
  localparam logic [7:0] SM8 = 8'(SETTLE_MAX);
  localparam logic [7:0] GW8 = 8'(GAP_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       lvl, lvl_n;
  logic       s_q, s_n;
  logic       r_q, r_n;
  logic       done_q, done_n;
  logic       err_q, err_n;

  logic cnt_last;
  logic match_req;
  logic match_lvl;

  assign cnt_last = (cnt == 8'd1);

  // Q==Qbar can never equal (x, ~x), so invalid feedback never matches.
  assign match_req = (bus.Q_fb == bus.req_level) &&
                     (bus.Qbar_fb == ~bus.req_level);
  assign match_lvl = (bus.Q_fb == lvl) &&
                     (bus.Qbar_fb == ~lvl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      lvl    <= 1'b0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      lvl    <= lvl_n;
      s_q    <= s_n;
      r_q    <= r_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lvl_n   = lvl;
    s_n     = 1'b0;
    r_n     = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          lvl_n = bus.req_level;
          if (match_req) begin
            done_n  = 1'b1;
            state_n = GAP;
            cnt_n   = GW8;
          end else begin
            state_n = PULSE;
            cnt_n   = PW8;
            s_n     = bus.req_level;
            r_n     = ~bus.req_level;
          end
        end
      end
      PULSE: begin
        if (cnt_last) begin
          state_n = SETTLE;
          cnt_n   = SM8;
        end else begin
          cnt_n = cnt - 8'd1;
          s_n   = lvl;
          r_n   = ~lvl;
        end
      end
      SETTLE: begin
        // Match is checked first so it wins over a coincident timeout.
        if (match_lvl) begin
          done_n  = 1'b1;
          state_n = GAP;
          cnt_n   = GW8;
        end else if (cnt_last) begin
          err_n   = 1'b1;
          state_n = GAP;
          cnt_n   = GW8;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt_last) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

endmodule
